reg_timeout_guard: RTL and testbench

- Sits on the register bus between an upstream master and one downstream slave.
- Uses the shared reg_req_t / reg_rsp_t types on both sides.
- Forwards transactions transparently. Counts wait cycles while a request is stalled.
- If the slave does not respond within TimeoutCycles, the block answers the master with an error and isolates the slave until software clears the fault. A hung peripheral therefore cannot lock up the bus.

---
 rtl/reg_pkg.sv | 33 +++
 rtl/reg_timeout_cnt.sv | 38 +++
 rtl/reg_timeout_guard.sv | 119 +++++++++++
 tb/tb_reg_timeout_guard.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared register-bus types plus the timeout-guard state enum and default error data.
package reg_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;

    typedef struct packed {
        addr_t addr;
        logic  write;
        data_t wdata;
        strb_t wstrb;
        logic  valid;
    } reg_req_t;

    typedef struct packed {
        data_t rdata;
        logic  error;
        logic  ready;
    } reg_rsp_t;

    typedef enum logic {
        PASS     = 1'b0,
        ISOLATED = 1'b1
    } reg_guard_state_e;

    localparam data_t REG_GUARD_ERR_DATA = 32'hBADC_AB1E;

endpackage

// File: rtl/reg_timeout_cnt.sv
// Wait-cycle counter: counts consecutive enabled cycles, flags the last allowed one.
module reg_timeout_cnt #(
    parameter int unsigned Width = 5,
    parameter int unsigned Limit = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [Width-1:0] LastVal = Width'(Limit - 1);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Any gap in the stall (valid low or slave ready) restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LastVal);

endmodule

// File: rtl/reg_timeout_guard.sv
// Register-bus guard: forwards traffic, errors out stalled requests and isolates a hung slave.
// Optional macro REG_TIMEOUT_GUARD_LOG_EN adds last_addr_o / to_count_o timeout logging.
module reg_timeout_guard
    import reg_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16,
    parameter data_t       ErrData       = REG_GUARD_ERR_DATA
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t req_i,
    output reg_rsp_t rsp_o,
    output reg_req_t req_o,
    input  reg_rsp_t rsp_i,
    input  logic     clear_i,
    output logic     timeout_o,
    output logic     isolated_o
`ifdef REG_TIMEOUT_GUARD_LOG_EN
    ,
    output addr_t      last_addr_o,
    output logic [7:0] to_count_o
`endif
);

    localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    reg_guard_state_e state_q;
    reg_guard_state_e state_d;
    logic             wait_en;
    logic             expire;
    reg_rsp_t         err_rsp;

    assign err_rsp = '{rdata: ErrData, error: 1'b1, ready: 1'b1};
    assign wait_en = (state_q == PASS) && req_i.valid && !rsp_i.ready;

    if (TimeoutCycles > 0) begin : g_cnt
        reg_timeout_cnt #(
            .Width (CntWidth),
            .Limit (TimeoutCycles)
        ) u_cnt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (wait_en),
            .clr_i    (expire),
            .expire_o (expire)
        );
    end else begin : g_no_cnt
        assign expire = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        req_o      = req_i;
        rsp_o      = rsp_i;
        timeout_o  = 1'b0;
        isolated_o = 1'b0;
        case (state_q)
            PASS: begin
                // expire already excludes a same-cycle slave ready, so the slave wins the race.
                if (expire) begin
                    rsp_o     = err_rsp;
                    timeout_o = 1'b1;
                    state_d   = ISOLATED;
                end
            end
            ISOLATED: begin
                isolated_o  = 1'b1;
                req_o.valid = 1'b0;
                rsp_o       = '0;
                if (req_i.valid) begin
                    rsp_o = err_rsp;
                end
                if (clear_i) begin
                    state_d = PASS;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef REG_TIMEOUT_GUARD_LOG_EN
    addr_t      last_addr_q;
    addr_t      last_addr_d;
    logic [7:0] to_count_q;
    logic [7:0] to_count_d;

    always_comb begin
        last_addr_d = last_addr_q;
        to_count_d  = to_count_q;
        if (timeout_o) begin
            last_addr_d = req_i.addr;
            if (to_count_q != 8'hFF) begin
                to_count_d = to_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_addr_q <= '0;
            to_count_q  <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            to_count_q  <= to_count_d;
        end
    end

    assign last_addr_o = last_addr_q;
    assign to_count_o  = to_count_q;
`endif

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Bench for reg_timeout_guard: directed scenarios plus random traffic against a cycle-level model.
module tb_reg_timeout_guard;
  import reg_pkg::*;

  localparam int unsigned T = 4;
  localparam data_t ERR = 32'hBADC_AB1E;

  logic     clk;
  logic     rst_n;
  reg_req_t req_i;
  reg_rsp_t rsp_o;
  reg_req_t req_o;
  reg_rsp_t rsp_i;
  logic     clear_i;
  logic     timeout_o;
  logic     isolated_o;
`ifdef REG_TIMEOUT_GUARD_LOG_EN
  addr_t      last_addr_o;
  logic [7:0] to_count_o;
`endif

  int checks = 0;
  int errors = 0;

  // stimulus driven into the next cycle
  reg_req_t drv_req;
  reg_rsp_t drv_rsp;
  logic     drv_clear;
  bit       last_done;
  bit       last_timeout;

  // reference model: how long the current request has waited, and whether the slave is fenced off
  int     m_wait;
  bit     m_iso;
  int     m_timeouts;
  addr_t  m_last_addr;
  int     m_to_count;

  reg_timeout_guard #(
    .TimeoutCycles (T),
    .ErrData       (ERR)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req_i),
    .rsp_o      (rsp_o),
    .req_o      (req_o),
    .rsp_i      (rsp_i),
    .clear_i    (clear_i),
    .timeout_o  (timeout_o),
    .isolated_o (isolated_o)
`ifdef REG_TIMEOUT_GUARD_LOG_EN
    ,
    .last_addr_o (last_addr_o),
    .to_count_o  (to_count_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait      = 0;
    m_iso       = 1'b0;
    m_last_addr = '0;
    m_to_count  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_ready"}, 32'(rsp_o.ready), 32'd0);
    check_eq({tag, "_rsp_error"}, 32'(rsp_o.error), 32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    check_eq({tag, "_isolated"}, 32'(isolated_o), 32'd0);
`ifdef REG_TIMEOUT_GUARD_LOG_EN
    check_eq({tag, "_last_addr"}, last_addr_o, 32'd0);
    check_eq({tag, "_to_count"}, 32'(to_count_o), 32'd0);
`endif
  endtask

  // driver: apply drv_* for one cycle, check outputs mid-cycle, advance the model
  task automatic step();
    bit    e_to;
    bit    e_ready;
    bit    e_err;
    bit    e_reqv;
    data_t e_rdata;
    req_i   = drv_req;
    rsp_i   = drv_rsp;
    clear_i = drv_clear;
    @(negedge clk);
    e_to = 1'b0;
    if (m_iso) begin
      e_reqv  = 1'b0;
      e_ready = drv_req.valid;
      e_err   = drv_req.valid;
      e_rdata = drv_req.valid ? ERR : '0;
    end else begin
      e_reqv = drv_req.valid;
      e_to   = drv_req.valid && !drv_rsp.ready && (m_wait == int'(T) - 1);
      if (e_to) begin
        e_ready = 1'b1;
        e_err   = 1'b1;
        e_rdata = ERR;
      end else begin
        e_ready = drv_rsp.ready;
        e_err   = drv_rsp.error;
        e_rdata = drv_rsp.rdata;
      end
    end
    check_eq("rsp_ready", 32'(rsp_o.ready), 32'(e_ready));
    check_eq("rsp_error", 32'(rsp_o.error), 32'(e_err));
    if (!m_iso || drv_req.valid) check_eq("rsp_rdata", rsp_o.rdata, e_rdata);
    check_eq("req_valid", 32'(req_o.valid), 32'(e_reqv));
    check_eq("req_addr", req_o.addr, drv_req.addr);
    check_eq("req_wdata", req_o.wdata, drv_req.wdata);
    check_eq("timeout", 32'(timeout_o), 32'(e_to));
    check_eq("isolated", 32'(isolated_o), 32'(m_iso));
`ifdef REG_TIMEOUT_GUARD_LOG_EN
    check_eq("last_addr", last_addr_o, m_last_addr);
    check_eq("to_count", 32'(to_count_o), 32'(m_to_count));
`endif
    if (m_iso) begin
      if (drv_clear) m_iso = 1'b0;
      m_wait = 0;
    end else if (e_to) begin
      m_iso       = 1'b1;
      m_wait      = 0;
      m_timeouts++;
      m_last_addr = drv_req.addr;
      if (m_to_count < 255) m_to_count++;
    end else if (drv_req.valid && !drv_rsp.ready) begin
      m_wait++;
    end else begin
      m_wait = 0;
    end
    last_done    = drv_req.valid && e_ready;
    last_timeout = e_to;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input addr_t addr, input bit write);
    drv_req.valid = 1'b1;
    drv_req.addr  = addr;
    drv_req.write = write;
    drv_req.wdata = $urandom;
    drv_req.wstrb = 4'(($urandom_range(0, 15)));
  endtask

  task automatic idle_all();
    drv_req   = '0;
    drv_rsp   = '0;
    drv_clear = 1'b0;
  endtask

  // hold a request against a stuck slave; returns the waiting-cycle index where the error came back
  task automatic hang_until_timeout(input addr_t addr, output int idx);
    idx = -1;
    new_req(addr, 1'b0);
    drv_rsp = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (last_done) begin
        if (last_timeout) idx = c;
        break;
      end
    end
    drv_req.valid = 1'b0;
  endtask

  initial begin
    int idx;
    bit hang;
    m_timeouts = 0;
    idle_all();
    req_i   = '0;
    rsp_i   = '0;
    clear_i = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // pass-through read, slave ready on the second cycle
    new_req(32'h10, 1'b0);
    step();
    check_eq("pt_cycle0_done", 32'(last_done), 32'd0);
    drv_rsp = '{rdata: 32'h1234_5678, error: 1'b0, ready: 1'b1};
    step();
    check_eq("pt_cycle1_done", 32'(last_done), 32'd1);
    idle_all();
    step();

    // race: slave answers in exactly the would-be timeout cycle
    new_req(32'h20, 1'b0);
    for (int c = 0; c < 3; c++) step();
    drv_rsp = '{rdata: 32'hCAFE_0001, error: 1'b0, ready: 1'b1};
    step();
    check_eq("race_no_timeout", 32'(last_timeout), 32'd0);
    check_eq("race_done", 32'(last_done), 32'd1);
    idle_all();
    step();

    // valid dropped mid-wait restarts the wait budget
    new_req(32'h24, 1'b0);
    for (int c = 0; c < 3; c++) step();
    drv_req.valid = 1'b0;
    step();
    drv_req.valid = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check_eq("drop_no_timeout", 32'(m_iso), 32'd0);
    idle_all();
    step();

    // hung slave at 0x40: error in the fourth waiting cycle
    hang_until_timeout(32'h40, idx);
    check_eq("hung_cycle", 32'(idx), 32'd3);
    step();

    // isolated traffic: three writes, each errored at once, late slave ready ignored
    drv_rsp = '{rdata: 32'h5555_5555, error: 1'b0, ready: 1'b1};
    for (int w = 0; w < 3; w++) begin
      new_req(32'h100 + addr_t'(w * 4), 1'b1);
      step();
      check_eq("iso_write_done", 32'(last_done), 32'd1);
    end
    idle_all();
    step();

    // clear together with a request: that one errored, the next goes through
    new_req(32'h50, 1'b0);
    drv_clear = 1'b1;
    step();
    drv_clear = 1'b0;
    new_req(32'h54, 1'b0);
    drv_rsp = '{rdata: 32'h0BAD_F00D, error: 1'b0, ready: 1'b1};
    step();
    check_eq("post_clear_ok", 32'(last_done && !last_timeout), 32'd1);
    idle_all();
    step();

    // second timeout at 0x80, then clear
    hang_until_timeout(32'h80, idx);
    check_eq("hung2_cycle", 32'(idx), 32'd3);
    drv_clear = 1'b1;
    step();
    drv_clear = 1'b0;
`ifdef REG_TIMEOUT_GUARD_LOG_EN
    check_eq("log_addr", last_addr_o, 32'h80);
    check_eq("log_count", 32'(to_count_o), 32'd2);
`endif

    // reset while isolated and mid-request
    hang_until_timeout(32'hC0, idx);
    new_req(32'hC4, 1'b0);
    step();
    req_i = drv_req;
    rsp_i = '0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    idle_all();
    req_i = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random traffic
    hang = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hang) begin
        drv_rsp.ready = 1'b0;
        if ($urandom_range(0, 9) == 0) hang = 1'b0;
      end else begin
        drv_rsp.ready = ($urandom_range(0, 1) == 0);
        if ($urandom_range(0, 24) == 0) hang = 1'b1;
      end
      drv_rsp.rdata = $urandom;
      drv_rsp.error = ($urandom_range(0, 7) == 0);
      drv_clear     = ($urandom_range(0, 7) == 0);
      step();
      if (last_done || !drv_req.valid) begin
        if ($urandom_range(0, 2) != 0) new_req($urandom, 1'($urandom_range(0, 1)));
        else drv_req.valid = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        drv_req.valid = 1'b0;
      end
    end
    check_eq("random_saw_timeouts", 32'(m_timeouts > 5), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
